// File: rtl/seq_multiplier_32_if.sv
// Operand/handshake/result bundle between the execute-stage operand muxes
// and the sequential multiplier.
interface seq_multiplier_32_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             signed_op;
  logic [WIDTH-1:0] operand_a;
  logic [WIDTH-1:0] operand_b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] product_high;
  logic [WIDTH-1:0] product_low;

  modport master (
    output start, signed_op, operand_a, operand_b,
    input  busy, done, product_high, product_low
  );

  modport slave (
    input  start, signed_op, operand_a, operand_b,
    output busy, done, product_high, product_low
  );
endinterface

// File: rtl/seq_multiplier_32.sv
// Iterative radix-2 shift-add multiplier producing a full 2*WIDTH-bit signed
// or unsigned product. Operands are multiplied as magnitudes and the sign is
// applied in a single FIXUP cycle; results are held until the next FIXUP.
module seq_multiplier_32 #(
  parameter int WIDTH = 32
) (
  input logic                clk,
  input logic                rst,
  seq_multiplier_32_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam int ACC_W = 2 * WIDTH + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    FIXUP = 2'd2
  } state_t;

  state_t state_r;
  state_t state_nxt_s;

  logic [WIDTH-1:0]   mcand_r,   mcand_nxt_s;
  logic [WIDTH-1:0]   mplier_r,  mplier_nxt_s;
  logic [ACC_W-1:0]   acc_r,     acc_nxt_s;
  logic [CNT_W-1:0]   cnt_r,     cnt_nxt_s;
  logic               neg_r,     neg_nxt_s;
  logic               busy_r,    busy_nxt_s;
  logic               done_r,    done_nxt_s;
  logic [WIDTH-1:0]   prod_hi_r, prod_hi_nxt_s;
  logic [WIDTH-1:0]   prod_lo_r, prod_lo_nxt_s;

  logic               last_iter_s;
  logic [WIDTH:0]     addend_s;
  logic [WIDTH:0]     upper_sum_s;
  logic [2*WIDTH-1:0] product_s;
  logic               neg_a_s;
  logic               neg_b_s;

  assign last_iter_s = (cnt_r == CNT_W'(WIDTH - 1));

  // The carry out of the upper-half add lands in the extra accumulator bit,
  // so nothing is lost before the right shift.
  assign addend_s    = mplier_r[0] ? {1'b0, mcand_r} : {(WIDTH + 1){1'b0}};
  assign upper_sum_s = acc_r[ACC_W-1:WIDTH] + addend_s;

  // Sign is re-applied to the magnitude product as a 2*WIDTH-bit two's complement.
  assign product_s = neg_r ? (-acc_r[2*WIDTH-1:0]) : acc_r[2*WIDTH-1:0];

  assign neg_a_s = bus.signed_op & bus.operand_a[WIDTH-1];
  assign neg_b_s = bus.signed_op & bus.operand_b[WIDTH-1];

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic: Start is only looked at in IDLE.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.start) begin
          state_nxt_s = CALC;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      CALC: begin
        if (last_iter_s) begin
          state_nxt_s = FIXUP;
        end else begin
          state_nxt_s = CALC;
        end
      end
      FIXUP: begin
        state_nxt_s = IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Output and datapath next values; everything holds unless the state acts on it.
  always_comb begin
    mcand_nxt_s   = mcand_r;
    mplier_nxt_s  = mplier_r;
    acc_nxt_s     = acc_r;
    cnt_nxt_s     = cnt_r;
    neg_nxt_s     = neg_r;
    busy_nxt_s    = busy_r;
    done_nxt_s    = 1'b0;
    prod_hi_nxt_s = prod_hi_r;
    prod_lo_nxt_s = prod_lo_r;
    case (state_r)
      IDLE: begin
        if (bus.start) begin
          mcand_nxt_s  = neg_a_s ? (-bus.operand_a) : bus.operand_a;
          mplier_nxt_s = neg_b_s ? (-bus.operand_b) : bus.operand_b;
          neg_nxt_s    = neg_a_s ^ neg_b_s;
          acc_nxt_s    = {ACC_W{1'b0}};
          cnt_nxt_s    = {CNT_W{1'b0}};
          busy_nxt_s   = 1'b1;
        end else begin
          busy_nxt_s   = 1'b0;
        end
      end
      CALC: begin
        acc_nxt_s    = {upper_sum_s, acc_r[WIDTH-1:0]} >> 1;
        mplier_nxt_s = mplier_r >> 1;
        cnt_nxt_s    = cnt_r + CNT_W'(1);
        busy_nxt_s   = 1'b1;
      end
      FIXUP: begin
        prod_hi_nxt_s = product_s[2*WIDTH-1:WIDTH];
        prod_lo_nxt_s = product_s[WIDTH-1:0];
        done_nxt_s    = 1'b1;
        busy_nxt_s    = 1'b0;
      end
      default: begin
        busy_nxt_s    = 1'b0;
      end
    endcase
  end

  // Datapath and output registers; reset also discards any in-flight operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand_r   <= {WIDTH{1'b0}};
      mplier_r  <= {WIDTH{1'b0}};
      acc_r     <= {ACC_W{1'b0}};
      cnt_r     <= {CNT_W{1'b0}};
      neg_r     <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      prod_hi_r <= {WIDTH{1'b0}};
      prod_lo_r <= {WIDTH{1'b0}};
    end else begin
      mcand_r   <= mcand_nxt_s;
      mplier_r  <= mplier_nxt_s;
      acc_r     <= acc_nxt_s;
      cnt_r     <= cnt_nxt_s;
      neg_r     <= neg_nxt_s;
      busy_r    <= busy_nxt_s;
      done_r    <= done_nxt_s;
      prod_hi_r <= prod_hi_nxt_s;
      prod_lo_r <= prod_lo_nxt_s;
    end
  end

  assign bus.busy         = busy_r;
  assign bus.done         = done_r;
  assign bus.product_high = prod_hi_r;
  assign bus.product_low  = prod_lo_r;

endmodule

// File: tb/tb_seq_multiplier_32.sv
// Scoreboard bench for seq_multiplier_32: expected products are queued when
// an operation is launched and compared when Done pulses.
module tb_seq_multiplier_32;

  logic clk;
  logic rst;

  seq_multiplier_32_if #(.WIDTH(32)) bus ();

  seq_multiplier_32 #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [63:0] exp_q[$];
  logic [63:0] prev_prod;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%h expected 0x%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    if (s) begin
      sa = $signed({{32{a[31]}}, a});
      sb = $signed({{32{b[31]}}, b});
      return sa * sb;
    end else begin
      return {32'd0, a} * {32'd0, b};
    end
  endfunction

  // Launch one operation, optionally pulse Start again at cycle pulse_at,
  // then wait (bounded) for Done and score the result and timing.
  task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic s, input int pulse_at);
    int          j;
    int          busy_cnt;
    bit          got;
    logic [63:0] e;
    @(negedge clk);
    bus.start     = 1'b1;
    bus.operand_a = a;
    bus.operand_b = b;
    bus.signed_op = s;
    exp_q.push_back(model(a, b, s));
    @(negedge clk);
    bus.start     = 1'b0;
    bus.operand_a = $urandom;
    bus.operand_b = $urandom;
    bus.signed_op = ~s;
    j = 0;
    busy_cnt = 0;
    got = 1'b0;
    while (!got && j < 100) begin
      if (bus.done) begin
        got = 1'b1;
      end else begin
        if (bus.busy) busy_cnt++;
        if (j == pulse_at) bus.start = 1'b1;
        if (j == pulse_at + 1) bus.start = 1'b0;
        if (j == 16) check_val({tag, "_hold"}, {bus.product_high, bus.product_low}, prev_prod);
        @(negedge clk);
        j++;
      end
    end
    bus.start = 1'b0;
    check_val({tag, "_latency"}, 64'(j), 64'd33);
    if (got) begin
      e = exp_q.pop_front();
      check_val({tag, "_product"}, {bus.product_high, bus.product_low}, e);
      check_val({tag, "_busy_at_done"}, 64'(bus.busy), 64'd0);
      prev_prod = e;
      @(negedge clk);
      check_val({tag, "_done_width"}, 64'(bus.done), 64'd0);
    end
    check_val({tag, "_busy_cycles"}, 64'(busy_cnt), 64'd33);
  endtask

  initial begin
    int          cyc;
    int          ndone;
    int          dones_seen;
    int          t[3];
    logic [63:0] e;

    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.signed_op = 1'b0;
    bus.operand_a = 32'd0;
    bus.operand_b = 32'd0;
    prev_prod     = 64'd0;
    repeat (3) @(negedge clk);
    check_val("rst_busy", 64'(bus.busy), 64'd0);
    check_val("rst_done", 64'(bus.done), 64'd0);
    check_val("rst_product", {bus.product_high, bus.product_low}, 64'd0);
    rst = 1'b0;

    do_op("u3x5", 32'd3, 32'd5, 1'b0, -1);
    check_val("u3x5_const", prev_prod, 64'h0000_0000_0000_000F);
    do_op("u_ff_ff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, -1);
    check_val("u_ff_ff_const", prev_prod, 64'hFFFF_FFFE_0000_0001);
    do_op("s_m1_m1", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, -1);
    check_val("s_m1_m1_const", prev_prod, 64'h0000_0000_0000_0001);
    do_op("s_m3_7", 32'hFFFF_FFFD, 32'd7, 1'b1, -1);
    check_val("s_m3_7_const", prev_prod, 64'hFFFF_FFFF_FFFF_FFEB);
    do_op("s_min_min", 32'h8000_0000, 32'h8000_0000, 1'b1, -1);
    check_val("s_min_min_const", prev_prod, 64'h4000_0000_0000_0000);
    do_op("s_m1_0", 32'hFFFF_FFFF, 32'd0, 1'b1, -1);
    do_op("u_mixed", 32'h8765_4321, 32'h1234_5678, 1'b0, -1);
    do_op("s_mixed", 32'h8765_4321, 32'h1234_5678, 1'b1, -1);
    do_op("start_while_busy", 32'd1234, 32'd5678, 1'b0, 5);

    // Abort an operation mid-CALC with reset.
    @(negedge clk);
    bus.start     = 1'b1;
    bus.operand_a = 32'd100;
    bus.operand_b = 32'd200;
    bus.signed_op = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    #1;
    check_val("abort_busy", 64'(bus.busy), 64'd0);
    check_val("abort_done", 64'(bus.done), 64'd0);
    check_val("abort_product", {bus.product_high, bus.product_low}, 64'd0);
    prev_prod = 64'd0;
    @(negedge clk);
    rst = 1'b0;
    dones_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done) dones_seen++;
    end
    check_val("abort_no_done", 64'(dones_seen), 64'd0);
    do_op("u6x7", 32'd6, 32'd7, 1'b0, -1);
    check_val("u6x7_const", prev_prod, 64'h0000_0000_0000_002A);

    // Start held high: one product every 34 cycles.
    @(negedge clk);
    bus.start     = 1'b1;
    bus.operand_a = 32'hDEAD_BEEF;
    bus.operand_b = 32'h0000_1001;
    bus.signed_op = 1'b1;
    for (int i = 0; i < 3; i++) exp_q.push_back(model(32'hDEAD_BEEF, 32'h0000_1001, 1'b1));
    ndone = 0;
    cyc = 0;
    while (ndone < 3 && cyc < 300) begin
      if (bus.done) begin
        e = exp_q.pop_front();
        check_val("held_product", {bus.product_high, bus.product_low}, e);
        t[ndone] = cyc;
        ndone++;
        if (ndone == 3) bus.start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    bus.start = 1'b0;
    check_val("held_count", 64'(ndone), 64'd3);
    if (ndone == 3) begin
      check_val("held_interval1", 64'(t[1] - t[0]), 64'd34);
      check_val("held_interval2", 64'(t[2] - t[1]), 64'd34);
    end
    dones_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done) dones_seen++;
    end
    check_val("held_release", 64'(dones_seen), 64'd0);
    check_val("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/seq_multiplier_32.md
# seq_multiplier_32

Iterative radix-2 shift-add multiplier for the execute stage. It sits directly downstream of the 2-to-1 32-bit operand select muxes and consumes their outputs as OperandA/OperandB. It produces a full 64-bit signed or unsigned product over 33 cycles using a Start/Busy/Done handshake. The result is held stable until the next operation completes.

## Interface
- WIDTH, 32, operand width; iteration count equals WIDTH; the product is 2*WIDTH bits.
- Clock  input  1  single clock; all state updates on the rising edge.
- Reset  input  1  asynchronous, active-high; forces the block to IDLE and clears all outputs.
- Start  input  1  request; sampled only in IDLE.
- Signed  input  1  1 = two's-complement operands; 0 = unsigned; captured with Start.
- OperandA  input  WIDTH  multiplicand; captured with Start.
- OperandB  input  WIDTH  multiplier; captured with Start.
- Busy  output  1  high while an operation is in progress (CALC or FIXUP).
- Done  output  1  one-cycle pulse when ProductHigh/ProductLow are updated.
- ProductHigh  output  WIDTH  upper half of the product.
- ProductLow  output  WIDTH  lower half of the product.

## Operation
- States: IDLE, CALC, FIXUP.
- IDLE, Start=1:
  - Capture operand magnitudes: in signed mode, a negative operand is negated; unsigned operands are taken as-is.
  - Capture the result sign NegRes = Signed & (A[MSB] ^ B[MSB]).
  - Clear the accumulator, set counter = 0, go to CALC.
- IDLE, Start=0: hold all registers.
- CALC, each cycle:
  - If the multiplier LSB is 1, add the multiplicand to the upper half of a 2*WIDTH+1-bit accumulator; the carry is kept.
  - Shift the accumulator right by 1 and shift the multiplier right by 1.
  - Increment the counter.
  - After the iteration with counter = WIDTH-1, go to FIXUP.
- FIXUP, one cycle:
  - Product = NegRes ? -accumulator : accumulator, computed as 2*WIDTH-bit two's complement.
  - Write ProductHigh/ProductLow, pulse Done, return to IDLE.
- Magnitude of 0x80000000 is 0x80000000 as unsigned; no overflow is possible. The product always fits in 64 bits.
- Start while Busy=1 is ignored; the in-flight operands are not disturbed.
- ProductHigh/ProductLow keep the previous result throughout a new operation and change only in the FIXUP cycle.
- A Start input that changes while Busy=1 has no effect on the captured operands or Signed.
- Reset at any time, including mid-CALC:
  - State becomes IDLE.
  - Busy = 0, Done = 0, ProductHigh = 0, ProductLow = 0.
  - Counter and accumulator are cleared.
  - The aborted operation produces no Done.

## Timing
- Reset values: Busy = 0, Done = 0, ProductHigh = 0, ProductLow = 0, state IDLE.
- Start sampled high at edge k in IDLE:
  - Busy = 1 from edge k through edge k+33.
  - CALC occupies edges k+1 to k+32.
  - FIXUP is evaluated at edge k+33, which writes the outputs.
- Done = 1 and the new product are visible for the cycle after edge k+33; Busy = 0 in that same cycle.
- Latency from the Start edge to the Done assertion: 33 cycles.
- Done lasts exactly one cycle.
- Back-to-back operation: Start held high during the Done cycle is sampled at edge k+34 and accepted. Maximum throughput is one product per 34 cycles.
- Outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- Reset then unsigned 3 x 5 -> after 33 cycles, Done = 1 for one cycle, ProductHigh = 0x00000000, ProductLow = 0x0000000F; Busy high for exactly 33 cycles.
- Unsigned 0xFFFFFFFF x 0xFFFFFFFF -> ProductHigh = 0xFFFFFFFE, ProductLow = 0x00000001; the same operands with Signed = 1 (-1 x -1) -> 0x00000000 / 0x00000001.
- Signed -3 x 7 -> ProductHigh = 0xFFFFFFFF, ProductLow = 0xFFFFFFEB.
- Signed 0x80000000 x 0x80000000 -> ProductHigh = 0x40000000, ProductLow = 0x00000000.
- Signed -1 x 0 (mux values A = -1, B = 0) -> 0x00000000 / 0x00000000.
- Start pulsed at cycle 5 of a busy operation with different operands -> ignored; the original result appears at cycle 33.
- Start held continuously -> Done pulses every 34 cycles.
- Reset asserted during CALC at cycle 10 -> Busy, Done and both products read 0 immediately; no Done follows; the next Start of 6 x 7 gives Low = 0x0000002A after 33 cycles.
